// File: rtl/cstn_pkg.sv
// Shared CSTN panel-bus definitions: default geometry, receiver state encoding
// and the 3-bit upper/lower interleave used by the 48-bit FIFO word.
package cstn_pkg;

    localparam int CSTN_H_ACT = 240;
    localparam int CSTN_V_ACT = 240;

    typedef enum logic {
        RX_IDLE   = 1'b0,
        RX_ACTIVE = 1'b1
    } rx_state_t;

    typedef struct packed {
        logic [23:0] ub;
        logic [23:0] lb;
    } cstn_pair_t;

    // Word layout alternates 3-bit groups, upper half first, MSB group first.
    function automatic logic [47:0] cstn_pack(input logic [23:0] ub, input logic [23:0] lb);
        logic [47:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            w[47-6*k -: 3] = ub[23-3*k -: 3];
            w[44-6*k -: 3] = lb[23-3*k -: 3];
        end
        return w;
    endfunction

    function automatic cstn_pair_t cstn_unpack(input logic [47:0] w);
        cstn_pair_t p;
        p = '0;
        for (int k = 0; k < 8; k++) begin
            p.ub[23-3*k -: 3] = w[47-6*k -: 3];
            p.lb[23-3*k -: 3] = w[44-6*k -: 3];
        end
        return p;
    endfunction

endpackage

// File: rtl/cstn_rx_if.sv
// CSTN panel bus plus the FIFO write port seen by the receiver.
// master = panel driver / FIFO side, slave = cstn_rx.
interface cstn_rx_if;
    logic        cstn_xck;
    logic        cstn_lp;
    logic        cstn_flm;
    logic [7:0]  cstn_ud;
    logic [7:0]  cstn_ld;
    logic [47:0] fifo_wdata;
    logic        fifo_we;
    logic        fifo_full;

    modport master (
        output cstn_xck, cstn_lp, cstn_flm, cstn_ud, cstn_ld, fifo_full,
        input  fifo_wdata, fifo_we
    );

    modport slave (
        input  cstn_xck, cstn_lp, cstn_flm, cstn_ud, cstn_ld, fifo_full,
        output fifo_wdata, fifo_we
    );
endinterface

// File: rtl/cstn_rx_sync.sv
// Optional two-flop input synchronizer (CSTN_RX_SYNC_EN) and edge detector.
// Data leaves from the same stage as XCK so a fall always sees settled bytes.
module cstn_rx_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       xck,
    input  logic       lp,
    input  logic       flm,
    input  logic [7:0] ud,
    input  logic [7:0] ld,
    output logic       xck_fall,
    output logic       lp_rise,
    output logic       flm_rise,
    output logic [7:0] ud_q,
    output logic [7:0] ld_q
);

    logic [18:0] bus_p0;
    logic [18:0] cur;
    logic [2:0]  prev_p1;

    assign bus_p0 = {xck, lp, flm, ud, ld};

`ifdef CSTN_RX_SYNC_EN
    logic [18:0] bus_p1;
    logic [18:0] bus_p2;

    // Whole bundle shares one depth so XCK/data alignment is preserved.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_p1 <= '0;
            bus_p2 <= '0;
        end else begin
            bus_p1 <= bus_p0;
            bus_p2 <= bus_p1;
        end
    end

    assign cur = bus_p2;
`else
    assign cur = bus_p0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev_p1 <= '0;
        else      prev_p1 <= cur[18:16];
    end

    assign xck_fall = prev_p1[2] & ~cur[18];
    assign lp_rise  = ~prev_p1[1] & cur[17];
    assign flm_rise = ~prev_p1[0] & cur[16];
    assign ud_q     = cur[15:8];
    assign ld_q     = cur[7:0];

endmodule

// File: rtl/cstn_rx.sv
// CSTN panel-bus receiver: rebuilds 48-bit pixel words from UD/LD bytes,
// tracks line/frame structure and flags errors. Optional: CSTN_RX_SYNC_EN.
module cstn_rx
    import cstn_pkg::*;
#(
    parameter int H_ACT = CSTN_H_ACT,
    parameter int V_ACT = CSTN_V_ACT,
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    cstn_rx_if.slave         bus,
    input  logic             err_clr,
    output logic [CNT_W-1:0] line_count,
    output logic             frame_done,
    output logic             err_line,
    output logic             err_ovf,
    output logic             err_frame
);

    localparam logic [CNT_W-1:0] H_LIM = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] V_LIM = CNT_W'(V_ACT);

    logic             xck_fall;
    logic             lp_rise;
    logic             flm_rise;
    logic [7:0]       ud_s;
    logic [7:0]       ld_s;

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] pix_nxt;
    logic [CNT_W-1:0] line_nxt;
    logic [1:0]       byte_idx;
    logic [1:0]       idx_nxt;
    logic             cap;
    logic             word_done;
    logic             done_nxt;
    logic             set_line;
    logic             set_frame;
    logic             set_ovf;
    logic             word_vld;
    logic [23:0]      ub;
    logic [23:0]      lb;

    cstn_rx_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .xck      (bus.cstn_xck),
        .lp       (bus.cstn_lp),
        .flm      (bus.cstn_flm),
        .ud       (bus.cstn_ud),
        .ld       (bus.cstn_ld),
        .xck_fall (xck_fall),
        .lp_rise  (lp_rise),
        .flm_rise (flm_rise),
        .ud_q     (ud_s),
        .ld_q     (ld_s)
    );

    always_comb begin
        state_nxt = state;
        pix_nxt   = pix_cnt;
        idx_nxt   = byte_idx;
        line_nxt  = line_count;
        cap       = 1'b0;
        word_done = 1'b0;
        done_nxt  = 1'b0;
        set_line  = 1'b0;
        set_frame = 1'b0;
        case (state)
            RX_IDLE: begin
                if (flm_rise) begin
                    state_nxt = RX_ACTIVE;
                    pix_nxt   = '0;
                    idx_nxt   = '0;
                    line_nxt  = '0;
                end
            end
            RX_ACTIVE: begin
                if (flm_rise) begin
                    set_frame = 1'b1;
                    pix_nxt   = '0;
                    idx_nxt   = '0;
                    line_nxt  = '0;
                end else begin
                    // Byte capture is resolved first so a coincident LP counts it.
                    if (xck_fall) begin
                        cap     = 1'b1;
                        pix_nxt = (pix_cnt == '1) ? pix_cnt : pix_cnt + CNT_W'(1);
                        if (byte_idx == 2'd2) begin
                            idx_nxt   = 2'd0;
                            word_done = 1'b1;
                        end else begin
                            idx_nxt = byte_idx + 2'd1;
                        end
                    end
                    if (lp_rise) begin
                        set_line = (pix_nxt != H_LIM) || (idx_nxt != 2'd0);
                        line_nxt = line_count + CNT_W'(1);
                        pix_nxt  = '0;
                        idx_nxt  = 2'd0;
                        if (line_nxt == V_LIM) begin
                            done_nxt  = 1'b1;
                            state_nxt = RX_IDLE;
                        end
                    end
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    assign set_ovf     = word_vld & bus.fifo_full;
    assign bus.fifo_we = word_vld & ~bus.fifo_full;

    always_ff @(posedge clk) begin
        if (cap) begin
            case (byte_idx)
                2'd0:    begin ub[23:16] <= ud_s; lb[23:16] <= ld_s; end
                2'd1:    begin ub[15:8]  <= ud_s; lb[15:8]  <= ld_s; end
                default: begin ub[7:0]   <= ud_s; lb[7:0]   <= ld_s; end
            endcase
        end
    end

    // Word is registered in the cycle after the third byte's XCK fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= RX_IDLE;
            pix_cnt        <= '0;
            byte_idx       <= '0;
            line_count     <= '0;
            frame_done     <= 1'b0;
            word_vld       <= 1'b0;
            bus.fifo_wdata <= '0;
            err_line       <= 1'b0;
            err_ovf        <= 1'b0;
            err_frame      <= 1'b0;
        end else begin
            state      <= state_nxt;
            pix_cnt    <= pix_nxt;
            byte_idx   <= idx_nxt;
            line_count <= line_nxt;
            frame_done <= done_nxt;
            word_vld   <= word_done;
            if (word_done)
                bus.fifo_wdata <= cstn_pack({ub[23:8], ud_s}, {lb[23:8], ld_s});
            err_line   <= set_line  | (err_line  & ~err_clr);
            err_ovf    <= set_ovf   | (err_ovf   & ~err_clr);
            err_frame  <= set_frame | (err_frame & ~err_clr);
        end
    end

endmodule
